ball_motion_ctrl: RTL and testbench

//  Sequences the ball datapath for the pong game: paces ball steps, moves the ball, and bounces it off walls and paddles.

---
 rtl/ball_motion_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_ctrl.sv
// Ball motion controller for pong: paces ball steps, moves and bounces the ball,
// and raises the miss/hit pulses that the game-state FSM consumes.
module ball_motion_ctrl #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int BALL_SIZE = 8,
    parameter int PADDLE_H  = 64,
    parameter int PADDLE_X1 = 16,
    parameter int PADDLE_X2 = 616,
    parameter int TICK_DIV  = 833333,
    parameter int PW        = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    state,
    input  logic [PW-1:0] paddle1_y,
    input  logic [PW-1:0] paddle2_y,
    output logic [PW-1:0] ball_x,
    output logic [PW-1:0] ball_y,
    output logic          miss1,
    output logic          miss2,
    output logic          hit
);

    localparam int              CW       = $clog2(TICK_DIV);
    localparam int              PW1      = PW + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [PW-1:0]   X_CTR    = PW'(H_RES / 2 - BALL_SIZE / 2);
    localparam logic [PW-1:0]   Y_CTR    = PW'(V_RES / 2 - BALL_SIZE / 2);
    localparam logic [PW-1:0]   X_MAX    = PW'(H_RES - BALL_SIZE);
    localparam logic [PW-1:0]   Y_MAX    = PW'(V_RES - BALL_SIZE);
    localparam logic [PW-1:0]   X_L_HIT  = PW'(PADDLE_X1);
    localparam logic [PW-1:0]   X_R_HIT  = PW'(PADDLE_X2 - BALL_SIZE);
    localparam logic [PW-1:0]   ONE      = PW'(1);
    localparam logic [PW:0]     BS_W     = PW1'(BALL_SIZE);
    localparam logic [PW:0]     PH_W     = PW1'(PADDLE_H);
    localparam logic [3:0]      ST_PLAY  = 4'b0010;

    typedef enum logic [1:0] {IDLE, MOVE, MISSED} ctrl_t;

    ctrl_t         ctrl_q;
    logic [CW-1:0] cnt_q;
    logic [PW-1:0] ball_x_q, ball_y_q, ball_x_d, ball_y_d;
    logic          dir_x_q, dir_y_q, dir_x_d, dir_y_d;   // 1 = right / down
    logic          miss1_q, miss2_q, hit_q;
    logic          miss1_d, miss2_d, hit_d;

    // Vertical extents compared one bit wider so paddles near the bottom never wrap.
    function automatic logic overlap(input logic [PW-1:0] by, input logic [PW-1:0] py);
        logic [PW:0] by_w, py_w;
        by_w = {1'b0, by};
        py_w = {1'b0, py};
        return ((by_w + BS_W) > py_w) && (by_w < (py_w + PH_W));
    endfunction

    always_comb begin
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dir_x_d  = dir_x_q;
        dir_y_d  = dir_y_q;
        hit_d    = 1'b0;
        miss1_d  = 1'b0;
        miss2_d  = 1'b0;

        if (dir_y_q) begin
            if (ball_y_q == Y_MAX) begin
                dir_y_d  = 1'b0;
                ball_y_d = ball_y_q - ONE;
            end else begin
                ball_y_d = ball_y_q + ONE;
            end
        end else begin
            if (ball_y_q == '0) begin
                dir_y_d  = 1'b1;
                ball_y_d = ball_y_q + ONE;
            end else begin
                ball_y_d = ball_y_q - ONE;
            end
        end

        if (!dir_x_q) begin
            if (ball_x_q == X_L_HIT && overlap(ball_y_q, paddle1_y)) begin
                dir_x_d  = 1'b1;
                ball_x_d = ball_x_q + ONE;
                hit_d    = 1'b1;
            end else if (ball_x_q == '0) begin
                miss1_d  = 1'b1;
            end else begin
                ball_x_d = ball_x_q - ONE;
            end
        end else begin
            if (ball_x_q == X_R_HIT && overlap(ball_y_q, paddle2_y)) begin
                dir_x_d  = 1'b0;
                ball_x_d = ball_x_q - ONE;
                hit_d    = 1'b1;
            end else if (ball_x_q == X_MAX) begin
                miss2_d  = 1'b1;
            end else begin
                ball_x_d = ball_x_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= IDLE;
            cnt_q    <= '0;
            ball_x_q <= X_CTR;
            ball_y_q <= Y_CTR;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            miss1_q  <= 1'b0;
            miss2_q  <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            miss1_q <= 1'b0;
            miss2_q <= 1'b0;
            hit_q   <= 1'b0;
            if (state != ST_PLAY) begin
                ctrl_q   <= IDLE;
                cnt_q    <= '0;
                ball_x_q <= X_CTR;
                ball_y_q <= Y_CTR;
            end else begin
                case (ctrl_q)
                    IDLE: begin
                        ctrl_q <= MOVE;
                        cnt_q  <= '0;
                    end
                    MOVE: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (miss1_d || miss2_d) begin
                                // Freeze the ball; serve direction points at the player who missed.
                                ctrl_q  <= MISSED;
                                miss1_q <= miss1_d;
                                miss2_q <= miss2_d;
                                dir_x_q <= miss2_d;
                            end else begin
                                ball_x_q <= ball_x_d;
                                ball_y_q <= ball_y_d;
                                dir_x_q  <= dir_x_d;
                                dir_y_q  <= dir_y_d;
                                hit_q    <= hit_d;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    MISSED: ctrl_q <= MISSED;
                    default: ctrl_q <= IDLE;
                endcase
            end
        end
    end

    assign ball_x = ball_x_q;
    assign ball_y = ball_y_q;
    assign miss1  = miss1_q;
    assign miss2  = miss2_q;
    assign hit    = hit_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: vector table, directed corner sequences and randomized
// play, all compared every cycle against an integer reference model of the ball.
module tb_ball_motion_ctrl;

    localparam int TICK = 4, HR = 640, VR = 480, BS = 8, PH = 64, X1 = 16, X2 = 616, PW = 10;
    localparam logic [3:0] NEW_GAME = 4'b0001, PLAY = 4'b0010, NEW_BALL = 4'b0100, GAME_OVER = 4'b1000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    state = NEW_GAME;
    logic [PW-1:0] paddle1_y = 10'd1000, paddle2_y = 10'd1000;
    logic [PW-1:0] ball_x, ball_y;
    logic          miss1, miss2, hit;

    ball_motion_ctrl #(
        .H_RES(HR), .V_RES(VR), .BALL_SIZE(BS), .PADDLE_H(PH),
        .PADDLE_X1(X1), .PADDLE_X2(X2), .TICK_DIV(TICK), .PW(PW)
    ) dut (
        .clk(clk), .reset(reset), .state(state),
        .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
        .ball_x(ball_x), .ball_y(ball_y),
        .miss1(miss1), .miss2(miss2), .hit(hit)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit chk_en = 1'b0;

    // Reference model: integer position and velocity; k counts PLAY edges in the episode.
    int mx = 316, my = 236, mvx = 1, mvy = 1, k = 0;
    bit frozen = 1'b0, em1 = 1'b0, em2 = 1'b0, ehit = 1'b0;

    function automatic bit ovl(input int y, input int p);
        return (y + BS > p) && (y < p + PH);
    endfunction

    always @(posedge clk) begin
        int nvy, ny, nx, nvx;
        em1 = 1'b0; em2 = 1'b0; ehit = 1'b0;
        if (reset) begin
            mx = 316; my = 236; mvx = 1; mvy = 1; k = 0; frozen = 1'b0;
        end else if (state != PLAY) begin
            mx = 316; my = 236; k = 0; frozen = 1'b0;
        end else begin
            k++;
            if (!frozen && k > 1 && (k - 1) % TICK == 0) begin
                nvy = mvy;
                if (my + mvy > VR - BS || my + mvy < 0) nvy = -mvy;
                ny = my + nvy;
                nx = mx; nvx = mvx;
                if (mvx < 0) begin
                    if (mx == X1 && ovl(my, int'(paddle1_y))) begin nvx = 1; nx = mx + 1; ehit = 1'b1; end
                    else if (mx == 0) em1 = 1'b1;
                    else nx = mx - 1;
                end else begin
                    if (mx + BS == X2 && ovl(my, int'(paddle2_y))) begin nvx = -1; nx = mx - 1; ehit = 1'b1; end
                    else if (mx == HR - BS) em2 = 1'b1;
                    else nx = mx + 1;
                end
                if (em1 || em2) begin
                    frozen = 1'b1;
                    mvx = em1 ? -1 : 1;
                end else begin
                    mx = nx; my = ny; mvx = nvx; mvy = nvy;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (chk_en) begin
            checks++;
            if (ball_x !== mx[PW-1:0] || ball_y !== my[PW-1:0] ||
                miss1 !== em1 || miss2 !== em2 || hit !== ehit) begin
                errors++;
                $display("FAIL model_cmp t=%0t: dut x=%0d y=%0d m1=%b m2=%b hit=%b, model x=%0d y=%0d m1=%b m2=%b hit=%b",
                         $time, ball_x, ball_y, miss1, miss2, hit, mx, my, em1, em2, ehit);
            end
        end
    endtask

    function automatic int track_p(input int y);
        int lo;
        lo = (y - 63 < 0) ? 0 : y - 63;
        return int'($urandom_range(y + 7, lo));
    endfunction

    typedef struct {
        logic [3:0] st;
        int         n;
        int         ex;
        int         ey;
        bit         pulse;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bit seen;
        int cnt_a, cnt_b, prev_y, hold_x, hold_y, mode;
        bit seen_top;

        tbl[0] = '{NEW_GAME,  1000, 316, 236, 1'b0};
        tbl[1] = '{PLAY,      1,    316, 236, 1'b0};
        tbl[2] = '{PLAY,      3,    316, 236, 1'b0};
        tbl[3] = '{PLAY,      1,    317, 237, 1'b0};
        tbl[4] = '{PLAY,      4,    318, 238, 1'b0};
        tbl[5] = '{NEW_BALL,  1,    316, 236, 1'b0};
        tbl[6] = '{PLAY,      5,    317, 237, 1'b0};
        tbl[7] = '{GAME_OVER, 3,    316, 236, 1'b0};
        tbl[8] = '{PLAY,      9,    318, 238, 1'b0};

        @(negedge clk);
        tick();
        tick();
        check("reset_x", ball_x, 316);
        check("reset_y", ball_y, 236);
        check("reset_pulses", {miss1, miss2, hit}, 0);
        reset = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            state = tbl[i].st;
            seen = 1'b0;
            for (int n = 0; n < tbl[i].n; n++) begin
                tick();
                if (miss1 || miss2 || hit) seen = 1'b1;
            end
            check($sformatf("vec%0d_x", i), ball_x, tbl[i].ex);
            check($sformatf("vec%0d_y", i), ball_y, tbl[i].ey);
            check($sformatf("vec%0d_pulse", i), seen, tbl[i].pulse);
        end

        // Bottom wall bounce, then right paddle hit with paddle2_y = ball_y-4
        for (int n = 0; n < 4000 && ball_y != 10'd472; n++) tick();
        check("reach_y_472", ball_y, 472);
        for (int n = 0; n < 8 && ball_y == 10'd472; n++) tick();
        check("bounce_bottom_y", ball_y, 471);
        for (int n = 0; n < 2000 && ball_x != 10'd608; n++) tick();
        check("reach_x_608", ball_x, 608);
        paddle2_y = (ball_y >= 10'd4) ? ball_y - 10'd4 : 10'd0;
        cnt_a = 0;
        for (int n = 0; n < 8 && ball_x == 10'd608; n++) begin
            tick();
            if (hit) cnt_a++;
        end
        check("hit_next_x", ball_x, 607);
        for (int n = 0; n < 6; n++) begin
            tick();
            if (hit) cnt_a++;
        end
        check("hit_pulse_count", cnt_a, 1);
        paddle2_y = 10'd1000;
        for (int n = 0; n < 8 && ball_x == 10'd607; n++) tick();
        check("moving_left_x", ball_x, 606);

        // Top wall bounce on the way left, then miss1 with freeze and leftward serve
        prev_y = int'(ball_y);
        seen_top = 1'b0;
        for (int n = 0; n < 5000 && !miss1; n++) begin
            tick();
            if (int'(ball_y) != prev_y) begin
                if (prev_y == 0) begin
                    check("bounce_top_y", ball_y, 1);
                    seen_top = 1'b1;
                end
                prev_y = int'(ball_y);
            end
        end
        check("top_bounce_seen", seen_top, 1);
        check("miss1_seen", miss1, 1);
        check("miss1_at_x", ball_x, 0);
        hold_x = int'(ball_x); hold_y = int'(ball_y);
        cnt_a = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (miss1 || miss2) cnt_a++;
        end
        check("miss1_single", cnt_a, 0);
        check("frozen_x", ball_x, hold_x);
        check("frozen_y", ball_y, hold_y);
        state = NEW_BALL;
        tick();
        check("recentre_x", ball_x, 316);
        check("recentre_y", ball_y, 236);
        state = PLAY;
        for (int n = 0; n < 10 && ball_x == 10'd316; n++) tick();
        check("serve_left_x", ball_x, 315);

        // Left paddle return, then miss2 on the right edge
        for (int n = 0; n < 2000 && ball_x != 10'd16; n++) tick();
        check("reach_x_16", ball_x, 16);
        paddle1_y = (ball_y >= 10'd4) ? ball_y - 10'd4 : 10'd0;
        cnt_b = 0;
        for (int n = 0; n < 4000 && !miss2; n++) begin
            tick();
            if (hit) cnt_b++;
        end
        check("left_hit_count", cnt_b, 1);
        check("miss2_seen", miss2, 1);
        check("miss2_at_x", ball_x, 632);
        cnt_a = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (miss1 || miss2 || hit) cnt_a++;
        end
        check("miss2_single", cnt_a, 0);
        check("frozen2_x", ball_x, 632);
        state = NEW_BALL;
        tick();
        check("recentre2_x", ball_x, 316);
        state = PLAY;
        for (int n = 0; n < 10 && ball_x == 10'd316; n++) tick();
        check("serve_right_x", ball_x, 317);

        // Reset while the tick counter is mid-count
        for (int n = 0; n < 6; n++) tick();
        reset = 1'b1;
        tick();
        check("midreset_x", ball_x, 316);
        check("midreset_y", ball_y, 236);
        check("midreset_pulses", {miss1, miss2, hit}, 0);
        reset = 1'b0;
        for (int n = 0; n < 5; n++) tick();
        check("after_reset_x", ball_x, 317);
        check("after_reset_y", ball_y, 237);

        // Randomized play
        mode = 0;
        for (int i = 0; i < 20000; i++) begin
            if (i % 64 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
                0: begin
                    paddle1_y = PW'(track_p(my));
                    paddle2_y = PW'(track_p(my));
                end
                1: begin
                    paddle1_y = ($urandom_range(0, 1) == 0 || my < 64) ? PW'(my + 8) : PW'(my - 64);
                    paddle2_y = ($urandom_range(0, 1) == 0 || my < 64) ? PW'(my + 8) : PW'(my - 64);
                end
                default: begin
                    paddle1_y = PW'($urandom_range(0, 1023));
                    paddle2_y = PW'($urandom_range(0, 1023));
                end
            endcase
            if ($urandom_range(0, 499) == 0) begin
                state = 4'($urandom_range(0, 15));
                if (state == PLAY) state = 4'b0000;
            end else begin
                state = PLAY;
            end
            reset = ($urandom_range(0, 2999) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
